// File: rtl/wb_cmd_pkg.sv
// ---------------------------------------------------------------------------
// wb_cmd_pkg
// Shared types for the UART-to-Wishbone command master: command opcodes,
// response status codes, SPECIAL sub-operations and the master FSM states.
// ---------------------------------------------------------------------------
package wb_cmd_pkg;

  // Two-bit opcode carried in the top bits of every command word
  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_SETADDR = 2'd2,
    OP_SPECIAL = 2'd3
  } opcode_e;

  // Two-bit status carried in the top bits of every response word
  typedef enum logic [1:0] {
    ST_RD_OK   = 2'd0,
    ST_WR_OK   = 2'd1,
    ST_BUS_ERR = 2'd2,
    ST_TIMEOUT = 2'd3
  } status_e;

  // SPECIAL sub-operations, taken from payload[1:0]
  localparam logic [1:0] SPC_NOP      = 2'd0;
  localparam logic [1:0] SPC_INC_ON   = 2'd1;
  localparam logic [1:0] SPC_INC_OFF  = 2'd2;
  localparam logic [1:0] SPC_ADDR_CLR = 2'd3;

  // Master FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RSP  = 2'd3
  } state_e;

endpackage

// File: rtl/wb_cmd_master.sv
// ---------------------------------------------------------------------------
// wb_cmd_master
// Pipelined Wishbone master fed by a {opcode, payload} command stream.
// READ/WRITE commands each run one single-beat bus transaction and produce
// one {status, data} response word. SETADDR/SPECIAL update the internal
// address / auto-increment state without touching the bus.
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   cmd_valid/ready/data: command channel, data = {opcode[1:0], payload[DW-1:0]}
//   rsp_valid/ready/data: response channel, data = {status[1:0], data[DW-1:0]}
//   o_wb_*              : Wishbone master outputs (cyc, stb, we, addr, data, sel)
//   i_wb_*              : Wishbone slave inputs (stall, ack, err, data)
//
// Every output comes straight from a flop (o_wb_sel is a constant).
// ---------------------------------------------------------------------------
module wb_cmd_master
  import wb_cmd_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255,
  parameter bit INC_RST = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [DW+1:0]   cmd_data,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW+1:0]   rsp_data,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data
);

  localparam logic [AW-1:0] ADDR_STEP = AW'(DW/8);
  // Counter value on the last cycle allowed before giving up
  localparam logic [15:0]   TMO_LAST  = 16'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            inc_q, inc_d;
  logic            we_q, we_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            cyc_q, cyc_d;
  logic            stb_q, stb_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW+1:0]   rsp_data_q, rsp_data_d;
  logic [15:0]     tmo_q, tmo_d;

  opcode_e         cmd_op;
  logic [DW-1:0]   cmd_payload;
  logic            fin;
  logic            fin_ok;
  status_e         fin_status;
  logic [DW-1:0]   fin_data;
  status_e         bus_status;
  logic [DW-1:0]   bus_data;

  assign cmd_op      = opcode_e'(cmd_data[DW+1:DW]);
  assign cmd_payload = cmd_data[DW-1:0];

  // Result of a slave termination; err takes priority over a simultaneous ack
  assign bus_status = i_wb_err ? ST_BUS_ERR : (we_q ? ST_WR_OK : ST_RD_OK);
  assign bus_data   = (i_wb_err || we_q) ? '0 : i_wb_data;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    inc_d       = inc_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    tmo_d       = tmo_q;
    fin         = 1'b0;
    fin_ok      = 1'b0;
    fin_status  = ST_RD_OK;
    fin_data    = '0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_READ, OP_WRITE: begin
              we_d  = (cmd_op == OP_WRITE);
              if (cmd_op == OP_WRITE) wdata_d = cmd_payload;
              cyc_d   = 1'b1;
              stb_d   = 1'b1;
              tmo_d   = '0;
              state_d = S_REQ;
            end
            OP_SETADDR: addr_d = cmd_payload[AW-1:0];
            default: begin
              case (cmd_payload[1:0])
                SPC_INC_ON:   inc_d  = 1'b1;
                SPC_INC_OFF:  inc_d  = 1'b0;
                SPC_ADDR_CLR: addr_d = '0;
                default:      ;
              endcase
            end
          endcase
        end
      end

      S_REQ: begin
        // Slave may accept the strobe and terminate it in the same cycle
        if (!i_wb_stall && (i_wb_ack || i_wb_err)) begin
          fin        = 1'b1;
          fin_ok     = !i_wb_err;
          fin_status = bus_status;
          fin_data   = bus_data;
        end else if (tmo_q == TMO_LAST) begin
          fin        = 1'b1;
          fin_status = ST_TIMEOUT;
        end else begin
          tmo_d = tmo_q + 16'd1;
          if (!i_wb_stall) begin
            stb_d   = 1'b0;
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (i_wb_ack || i_wb_err) begin
          fin        = 1'b1;
          fin_ok     = !i_wb_err;
          fin_status = bus_status;
          fin_data   = bus_data;
        end else if (tmo_q == TMO_LAST) begin
          fin        = 1'b1;
          fin_status = ST_TIMEOUT;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      default: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
    endcase

    // Common bus termination: release the bus and present the response
    if (fin) begin
      cyc_d       = 1'b0;
      stb_d       = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_data_d  = {fin_status, fin_data};
      state_d     = S_RSP;
      if (fin_ok && inc_q) addr_d = addr_q + ADDR_STEP;
    end

    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      inc_q       <= INC_RST;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      inc_q       <= inc_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      tmo_q       <= tmo_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = stb_q;
  assign o_wb_we   = we_q;
  assign o_wb_addr = addr_q;
  assign o_wb_data = wdata_q;
  assign o_wb_sel  = '1;

endmodule

// File: tb/tb_wb_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_wb_cmd_master
// Directed bench for wb_cmd_master (DW=AW=32, TIMEOUT=8, INC_RST=1).
// The slave side is driven by hand, cycle by cycle, and every expected value
// below is worked out from the intended behaviour of the master.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_cmd_master;

  localparam int DW = 32;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [DW+1:0]   cmd_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW+1:0]   rsp_data;
  logic            o_wb_cyc;
  logic            o_wb_stb;
  logic            o_wb_we;
  logic [AW-1:0]   o_wb_addr;
  logic [DW-1:0]   o_wb_data;
  logic [DW/8-1:0] o_wb_sel;
  logic            i_wb_stall;
  logic            i_wb_ack;
  logic            i_wb_err;
  logic [DW-1:0]   i_wb_data;

  int vecCount  = 0;
  int missCount = 0;

  wb_cmd_master #(.DW(DW), .AW(AW), .TIMEOUT(8), .INC_RST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .i_wb_data(i_wb_data)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts every check and reports a miscompare
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one command and hold it until the accepting edge has passed
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] payload);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      n++;
      tick();
    end
    if (n >= 50) checkOutput("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_data  = {op, payload};
    tick();
    cmd_valid = 1'b0;
    cmd_data  = '0;
  endtask

  // One READ/WRITE, optional stall cycles, terminated in WAIT by ack and/or err,
  // optional response backpressure of 'hold' cycles
  task automatic busTxn(input string tag, input logic [1:0] op, input logic [31:0] payload,
                        input int stalls, input bit ack, input bit err, input logic [31:0] rdata,
                        input logic [33:0] expRsp, input logic [31:0] expAddr, input int hold);
    applyStimulus(op, payload);
    checkOutput({tag, ":stb"}, o_wb_stb, 1);
    checkOutput({tag, ":addr"}, o_wb_addr, expAddr);
    checkOutput({tag, ":we"}, o_wb_we, (op == 2'd1));
    if (op == 2'd1) checkOutput({tag, ":wdata"}, o_wb_data, payload);
    i_wb_stall = (stalls > 0);
    for (int i = 0; i < stalls; i++) begin
      tick();
      checkOutput({tag, ":stall_stb"}, o_wb_stb, 1);
      checkOutput({tag, ":stall_addr"}, o_wb_addr, expAddr);
      checkOutput({tag, ":stall_rdy"}, cmd_ready, 0);
      if (i == stalls - 1) i_wb_stall = 1'b0;
    end
    tick();
    checkOutput({tag, ":wait_stb"}, o_wb_stb, 0);
    checkOutput({tag, ":wait_cyc"}, o_wb_cyc, 1);
    i_wb_ack  = ack;
    i_wb_err  = err;
    i_wb_data = rdata;
    rsp_ready = (hold == 0);
    tick();
    i_wb_ack  = 1'b0;
    i_wb_err  = 1'b0;
    i_wb_data = '0;
    checkOutput({tag, ":rsp_valid"}, rsp_valid, 1);
    checkOutput({tag, ":rsp_data"}, rsp_data, expRsp);
    checkOutput({tag, ":rsp_cyc"}, o_wb_cyc, 0);
    for (int h = 0; h < hold; h++) begin
      tick();
      checkOutput({tag, ":hold_valid"}, rsp_valid, 1);
      checkOutput({tag, ":hold_data"}, rsp_data, expRsp);
      checkOutput({tag, ":hold_rdy"}, cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    checkOutput({tag, ":done_valid"}, rsp_valid, 0);
    checkOutput({tag, ":done_rdy"}, cmd_ready, 1);
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_data   = '0;
    rsp_ready  = 1'b1;
    i_wb_stall = 1'b0;
    i_wb_ack   = 1'b0;
    i_wb_err   = 1'b0;
    i_wb_data  = '0;

    // Reset values
    tick();
    tick();
    checkOutput("rst_cyc", o_wb_cyc, 0);
    checkOutput("rst_stb", o_wb_stb, 0);
    checkOutput("rst_we", o_wb_we, 0);
    checkOutput("rst_addr", o_wb_addr, 0);
    checkOutput("rst_wdata", o_wb_data, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    checkOutput("rst_sel", o_wb_sel, 4'hF);
    rst_n = 1'b1;
    tick();
    checkOutput("rst_rdy", cmd_ready, 1);

    // Auto-increment is on out of reset
    busTxn("rd0", 2'd0, 32'h0, 0, 1'b1, 1'b0, 32'h1234_5678, {2'd0, 32'h1234_5678}, 32'h0, 0);
    checkOutput("rd0_inc", o_wb_addr, 32'h4);

    // SETADDR then WRITE with increment
    applyStimulus(2'd2, 32'h100);
    checkOutput("setaddr", o_wb_addr, 32'h100);
    checkOutput("setaddr_cyc", o_wb_cyc, 0);
    busTxn("wr", 2'd1, 32'hDEAD_BEEF, 0, 1'b1, 1'b0, 32'h0, {2'd1, 32'h0}, 32'h100, 0);
    checkOutput("wr_inc", o_wb_addr, 32'h104);

    // Increment off: both reads at the same address
    applyStimulus(2'd3, 32'h2);
    applyStimulus(2'd2, 32'h20);
    busTxn("rdA", 2'd0, 32'h0, 0, 1'b1, 1'b0, 32'h11, {2'd0, 32'h11}, 32'h20, 0);
    busTxn("rdB", 2'd0, 32'h0, 0, 1'b1, 1'b0, 32'h22, {2'd0, 32'h22}, 32'h20, 0);
    checkOutput("noinc_addr", o_wb_addr, 32'h20);

    // Three stall cycles
    busTxn("stall", 2'd0, 32'h0, 3, 1'b1, 1'b0, 32'h33, {2'd0, 32'h33}, 32'h20, 0);

    // Increment back on for the failure cases, which must not increment
    applyStimulus(2'd3, 32'h1);

    // Timeout: slave never answers, cyc held for exactly 8 cycles
    applyStimulus(2'd1, 32'h55);
    checkOutput("tmo_addr", o_wb_addr, 32'h20);
    n = 0;
    while (o_wb_cyc && n < 40) begin
      n++;
      tick();
    end
    checkOutput("tmo_cycles", n, 8);
    checkOutput("tmo_rsp_valid", rsp_valid, 1);
    checkOutput("tmo_rsp_data", rsp_data, {2'd3, 32'h0});
    tick();
    tick();
    i_wb_ack = 1'b1;
    tick();
    i_wb_ack = 1'b0;
    tick();
    checkOutput("tmo_late_cyc", o_wb_cyc, 0);
    checkOutput("tmo_late_valid", rsp_valid, 0);
    checkOutput("tmo_late_addr", o_wb_addr, 32'h20);

    // ack and err together, response held off for 5 cycles
    busTxn("err", 2'd0, 32'h0, 0, 1'b1, 1'b1, 32'h77, {2'd2, 32'h0}, 32'h20, 5);
    checkOutput("err_addr", o_wb_addr, 32'h20);

    // SPECIAL address clear
    applyStimulus(2'd2, 32'h40);
    applyStimulus(2'd3, 32'h3);
    checkOutput("spc_clr", o_wb_addr, 32'h0);

    // Address wrap on increment
    applyStimulus(2'd2, 32'hFFFF_FFFC);
    busTxn("wrap", 2'd0, 32'h0, 0, 1'b1, 1'b0, 32'hA5, {2'd0, 32'hA5}, 32'hFFFF_FFFC, 0);
    checkOutput("wrap_addr", o_wb_addr, 32'h0);

    // Reset during WAIT aborts without a response
    applyStimulus(2'd0, 32'h0);
    tick();
    checkOutput("abort_wait_cyc", o_wb_cyc, 1);
    rst_n = 1'b0;
    tick();
    checkOutput("abort_cyc", o_wb_cyc, 0);
    checkOutput("abort_stb", o_wb_stb, 0);
    checkOutput("abort_valid", rsp_valid, 0);
    checkOutput("abort_addr", o_wb_addr, 32'h0);
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("post_abort_valid", rsp_valid, 0);
    checkOutput("post_abort_rdy", cmd_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
